// File: rtl/fft_stream_checker.sv
// fft_stream_checker
//
// Compares a LANES-wide complex output stream from the FFT core against a
// stream of golden samples. Golden beats are queued in an internal FIFO so the
// two streams may arrive with arbitrary latency skew. Each DUT beat pops one
// golden beat and is compared lane by lane within a +/-TOL window on both the
// real and imaginary components. Frame/error statistics and the first mismatch
// are kept so a regression can report a verdict without post-processing.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear               zero statistics and sticky flags; FIFO contents kept
//   exp_valid/exp_data  golden beat, lane k at [(k+1)*2*NBITS_OUT-1 : k*2*NBITS_OUT] as {re, im}
//   dut_valid/dut_data  FFT output beat, same packing
//   cmp_valid           a comparison result is presented this cycle
//   cmp_pass, lane_fail overall verdict and per-lane fail flags of that beat
//   frame_done          that beat was the last of a frame
//   beat_index          index of that beat within its frame
//   frame_count         completed frames (wraps)
//   err_count           failing beats (saturates)
//   first_err_*         capture of the first failing beat since rst/clear
//   fifo_ovf, fifo_udf  sticky overflow / underflow flags
//   exp_level           FIFO occupancy
module fft_stream_checker #(
    parameter int NBITS_OUT  = 21,
    parameter int LANES      = 4,
    parameter int N          = 128,
    parameter int TOL        = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int CNTW       = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                exp_valid,
    input  logic [LANES*2*NBITS_OUT-1:0]        exp_data,
    input  logic                                dut_valid,
    input  logic [LANES*2*NBITS_OUT-1:0]        dut_data,
    output logic                                cmp_valid,
    output logic                                cmp_pass,
    output logic [LANES-1:0]                    lane_fail,
    output logic                                frame_done,
    output logic [$clog2(N/LANES)-1:0]          beat_index,
    output logic [CNTW-1:0]                     frame_count,
    output logic [CNTW-1:0]                     err_count,
    output logic                                first_err_valid,
    output logic [CNTW-1:0]                     first_err_frame,
    output logic [$clog2(N/LANES)-1:0]          first_err_index,
    output logic [LANES-1:0]                    first_err_lanes,
    output logic                                fifo_ovf,
    output logic                                fifo_udf,
    output logic [$clog2(FIFO_DEPTH):0]         exp_level
);

    localparam int BEATS = N / LANES;
    localparam int IDXW  = $clog2(BEATS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = 2 * NBITS_OUT;
    localparam int DW    = LANES * CW;

    logic [DW-1:0]   fifoMem [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [DW-1:0]   headData;
    logic            fifoFull;
    logic            fifoEmpty;
    logic            doPush;
    logic            doPop;
    logic [LANES-1:0] laneFailNext;
    logic            beatFails;
    logic            lastBeat;
    logic [IDXW-1:0] beatCnt;       // index the next compared beat will get

    // Component check on sign-extended operands: one extra bit keeps the
    // difference of two extreme values from wrapping into a small magnitude.
    function automatic logic compFail(input logic [NBITS_OUT-1:0] a,
                                      input logic [NBITS_OUT-1:0] b);
        logic [NBITS_OUT:0] diff;
        logic [NBITS_OUT:0] mag;
        diff = {a[NBITS_OUT-1], a} - {b[NBITS_OUT-1], b};
        mag  = diff[NBITS_OUT] ? -diff : diff;
        return mag > (NBITS_OUT+1)'(TOL);
    endfunction

    assign fifoFull  = (exp_level == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
    assign fifoEmpty = (exp_level == '0);
    // A pop only sees entries present at the start of the cycle.
    assign doPop     = dut_valid && !fifoEmpty;
    // Pushing into a full FIFO is fine when the head leaves in the same cycle.
    assign doPush    = exp_valid && (!fifoFull || doPop);
    assign headData  = fifoMem[rdPtr];
    assign lastBeat  = (beatCnt == IDXW'(BEATS - 1));

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        laneFailNext = '0;
        for (int k = 0; k < LANES; k++) begin
            laneFailNext[k] =
                compFail(dut_data[k*CW+NBITS_OUT +: NBITS_OUT], headData[k*CW+NBITS_OUT +: NBITS_OUT]) |
                compFail(dut_data[k*CW +: NBITS_OUT],           headData[k*CW +: NBITS_OUT]);
        end
    end

    assign beatFails = |laneFailNext;

    // NOTE: the storage array is deliberately left out of reset; the pointers
    // and level define which entries are meaningful, so clearing the array
    // would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem[wrPtr] <= exp_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr           <= '0;
            rdPtr           <= '0;
            exp_level       <= '0;
            cmp_valid       <= 1'b0;
            cmp_pass        <= 1'b0;
            lane_fail       <= '0;
            frame_done      <= 1'b0;
            beat_index      <= '0;
            beatCnt         <= '0;
            frame_count     <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_frame <= '0;
            first_err_index <= '0;
            first_err_lanes <= '0;
            fifo_ovf        <= 1'b0;
            fifo_udf        <= 1'b0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      exp_level <= exp_level + 1'b1;
            else if (!doPush && doPop) exp_level <= exp_level - 1'b1;

            // Per-beat report; still produced on a clear cycle.
            cmp_valid  <= doPop;
            frame_done <= doPop && lastBeat;
            if (doPop) begin
                cmp_pass  <= !beatFails;
                lane_fail <= laneFailNext;
            end

            if (clear) begin
                beat_index      <= '0;
                beatCnt         <= '0;
                frame_count     <= '0;
                err_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_frame <= '0;
                first_err_index <= '0;
                first_err_lanes <= '0;
                fifo_ovf        <= 1'b0;
                fifo_udf        <= 1'b0;
            end else begin
                // A golden beat that could not be pushed was dropped.
                if (exp_valid && !doPush) fifo_ovf <= 1'b1;
                if (dut_valid && fifoEmpty) fifo_udf <= 1'b1;
                if (doPop) begin
                    beat_index <= beatCnt;
                    beatCnt    <= beatCnt + 1'b1;   // BEATS is a power of 2
                    if (lastBeat) frame_count <= frame_count + 1'b1;
                    if (beatFails) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_frame <= frame_count;
                            first_err_index <= beatCnt;
                            first_err_lanes <= laneFailNext;
                        end
                    end
                end
            end
        end
    end

endmodule
